issue_scoreboard: RTL and testbench

//  Parametrised register scoreboard and issue interlock for the pipelined core.

---
 rtl/issue_scoreboard.sv | 115 +++++++++++
 tb/tb_issue_scoreboard.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write counters plus a mult/div busy flag.
// issue_ready is combinational. A same-cycle retire or kill is seen as written through to decode.
module issue_scoreboard #(
   parameter int NREG = 32,
   parameter int RW   = 5,
   parameter int CW   = 2,
   parameter int TW   = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            dec_valid,
   input  logic [RW-1:0]   dec_rs,
   input  logic            dec_rs_used,
   input  logic [RW-1:0]   dec_rt,
   input  logic            dec_rt_used,
   input  logic [RW-1:0]   dec_rd,
   input  logic            dec_rd_wr,
   input  logic            dec_long,
   input  logic            wb_valid,
   input  logic [RW-1:0]   wb_rd,
   input  logic            kill_valid,
   input  logic [RW-1:0]   kill_rd,
   input  logic            long_done,
   output logic            issue_ready,
   output logic [NREG-1:0] pending_mask,
   output logic [TW-1:0]   inflight_cnt,
   output logic            long_busy,
   output logic            err_underflow
);

   // Two extra bits hold the +1/-2 range of a one-cycle update without wrapping.
   localparam int XW = CW + 2;

   logic [CW-1:0] cnt_q [NREG];
   logic [CW-1:0] cnt_d [NREG];
   logic [TW-1:0] inflight_q, inflight_d;
   logic          long_busy_q, long_busy_d;
   logic          err_q, err_d;

   logic          issue_fire;
   logic          raw_rs, raw_rt, waw_sat, long_haz;
   logic [XW-1:0] rs_rel, rt_rel;
   logic          rd_rel;

   always_comb begin
      rs_rel = XW'(wb_valid && (wb_rd == dec_rs)) + XW'(kill_valid && (kill_rd == dec_rs));
      rt_rel = XW'(wb_valid && (wb_rd == dec_rt)) + XW'(kill_valid && (kill_rd == dec_rt));
      rd_rel = (wb_valid && (wb_rd == dec_rd)) || (kill_valid && (kill_rd == dec_rd));

      raw_rs   = dec_rs_used && (dec_rs != '0) && (XW'(cnt_q[dec_rs]) > rs_rel);
      raw_rt   = dec_rt_used && (dec_rt != '0) && (XW'(cnt_q[dec_rt]) > rt_rel);
      waw_sat  = dec_rd_wr && (dec_rd != '0) && (cnt_q[dec_rd] == '1) && !rd_rel;
      long_haz = dec_long && long_busy_q && !long_done;

      issue_ready = !raw_rs && !raw_rt && !waw_sat && !long_haz;
      issue_fire  = dec_valid && issue_ready;
   end

   always_comb begin
      logic [XW-1:0] nxt;
      logic          inc, dwb, dkl;
      cnt_d      = cnt_q;
      cnt_d[0]   = '0;
      inflight_d = inflight_q;
      err_d      = err_q;
      nxt        = '0;
      inc        = 1'b0;
      dwb        = 1'b0;
      dkl        = 1'b0;
      for (int i = 1; i < NREG; i++) begin
         inc = issue_fire && dec_rd_wr && (dec_rd == RW'(i));
         dwb = wb_valid && (wb_rd == RW'(i));
         dkl = kill_valid && (kill_rd == RW'(i));
         nxt = XW'(cnt_q[i]) + XW'(inc) - XW'(dwb) - XW'(dkl);
         if (nxt[XW-1]) begin
            cnt_d[i] = '0;
            err_d    = 1'b1;
         end else begin
            cnt_d[i] = nxt[CW-1:0];
         end
         // The total follows the clamped per-register change, so it never drifts from the counters.
         inflight_d = inflight_d + TW'(cnt_d[i]) - TW'(cnt_q[i]);
      end

      if (issue_fire && dec_long)
         long_busy_d = 1'b1;
      else if (long_done)
         long_busy_d = 1'b0;
      else
         long_busy_d = long_busy_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
         inflight_q  <= '0;
         long_busy_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
         inflight_q  <= inflight_d;
         long_busy_q <= long_busy_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) pending_mask[i] = (cnt_q[i] != '0);
   end

   assign inflight_cnt  = inflight_q;
   assign long_busy     = long_busy_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazards, saturation, simultaneous updates, long unit, reset.
module tb_issue_scoreboard;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        dec_valid, dec_rs_used, dec_rt_used, dec_rd_wr, dec_long;
   logic [4:0]  dec_rs, dec_rt, dec_rd, wb_rd, kill_rd;
   logic        wb_valid, kill_valid, long_done;
   logic        issue_ready, long_busy, err_underflow;
   logic [31:0] pending_mask;
   logic [3:0]  inflight_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   issue_scoreboard #(.NREG(32), .RW(5), .CW(2), .TW(4)) dut (
      .clock(clock), .reset(reset),
      .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used),
      .dec_rt(dec_rt), .dec_rt_used(dec_rt_used), .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr),
      .dec_long(dec_long), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .kill_valid(kill_valid), .kill_rd(kill_rd), .long_done(long_done),
      .issue_ready(issue_ready), .pending_mask(pending_mask), .inflight_cnt(inflight_cnt),
      .long_busy(long_busy), .err_underflow(err_underflow)
   );

   task automatic idle();
      dec_valid = 0; dec_rs = 0; dec_rs_used = 0; dec_rt = 0; dec_rt_used = 0;
      dec_rd = 0; dec_rd_wr = 0; dec_long = 0;
      wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0; long_done = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      #3;
      reset = 1'b1;
      tick();
   endtask

   task automatic issue_rd(input logic [4:0] rd);
      idle();
      dec_valid = 1; dec_rd_wr = 1; dec_rd = rd;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #2;
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
      checks++; if (inflight_cnt !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight_cnt); end
      checks++; if (long_busy !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b err=%b want 0 0", long_busy, err_underflow); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue_rd(5);
      issue_rd(5);
      idle(); dec_valid = 1; dec_long = 1;
      tick();
      idle();
      checks++; if (inflight_cnt !== 4'd2 || pending_mask !== 32'h20 || long_busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got inflight=%0d mask=%h busy=%b want 2 00000020 1", inflight_cnt, pending_mask, long_busy); end
      #2 reset = 1'b0;
      #1;
      checks++; if (pending_mask !== 32'h0 || inflight_cnt !== 4'd0 || long_busy !== 1'b0) begin errors++; $display("FAIL mid_reset: got mask=%h inflight=%0d busy=%b want 0 0 0", pending_mask, inflight_cnt, long_busy); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_raw();
      do_reset();
      issue_rd(3);
      checks++; if (pending_mask !== 32'h8 || inflight_cnt !== 4'd1) begin errors++; $display("FAIL raw_issue: got mask=%h inflight=%0d want 00000008 1", pending_mask, inflight_cnt); end
      dec_valid = 1; dec_rs = 3; dec_rs_used = 1;
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_rs_stall: got %b want 0", issue_ready); end
      dec_rs_used = 0; dec_rt = 3;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_unused: got %b want 1", issue_ready); end
      dec_rt_used = 1;
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_rt_stall: got %b want 0", issue_ready); end
      dec_rt_used = 0; dec_rs_used = 1; wb_valid = 1; wb_rd = 3;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_through: got %b want 1", issue_ready); end
      tick();
      idle();
      checks++; if (pending_mask !== 32'h0 || inflight_cnt !== 4'd0) begin errors++; $display("FAIL raw_retired: got mask=%h inflight=%0d want 0 0", pending_mask, inflight_cnt); end
      issue_rd(3);
      dec_valid = 1; dec_rt = 3; dec_rt_used = 1; kill_valid = 1; kill_rd = 3;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_kill_through: got %b want 1", issue_ready); end
      tick();
      idle();
      checks++; if (inflight_cnt !== 4'd0 || err_underflow !== 1'b0) begin errors++; $display("FAIL raw_killed: got inflight=%0d err=%b want 0 0", inflight_cnt, err_underflow); end
   endtask

   task automatic test_waw();
      do_reset();
      for (int k = 0; k < 3; k++) issue_rd(7);
      checks++; if (inflight_cnt !== 4'd3 || pending_mask !== 32'h80) begin errors++; $display("FAIL waw_fill: got inflight=%0d mask=%h want 3 00000080", inflight_cnt, pending_mask); end
      dec_valid = 1; dec_rd_wr = 1; dec_rd = 7;
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_sat: got %b want 0", issue_ready); end
      tick();
      checks++; if (inflight_cnt !== 4'd3) begin errors++; $display("FAIL waw_held: got %0d want 3", inflight_cnt); end
      wb_valid = 1; wb_rd = 7;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_wb_ready: got %b want 1", issue_ready); end
      tick();
      idle();
      checks++; if (inflight_cnt !== 4'd3 || err_underflow !== 1'b0) begin errors++; $display("FAIL waw_net: got inflight=%0d err=%b want 3 0", inflight_cnt, err_underflow); end
      dec_valid = 1; dec_rd_wr = 1; dec_rd = 7; kill_valid = 1; kill_rd = 7;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_kill_ready: got %b want 1", issue_ready); end
      idle();
   endtask

   task automatic test_simul();
      do_reset();
      issue_rd(4);
      issue_rd(4);
      checks++; if (inflight_cnt !== 4'd2) begin errors++; $display("FAIL sim_pre: got %0d want 2", inflight_cnt); end
      dec_valid = 1; dec_rd_wr = 1; dec_rd = 4;
      wb_valid = 1; wb_rd = 4; kill_valid = 1; kill_rd = 4;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b want 1", issue_ready); end
      tick();
      idle();
      checks++; if (inflight_cnt !== 4'd1 || pending_mask !== 32'h10) begin errors++; $display("FAIL sim_net: got inflight=%0d mask=%h want 1 00000010", inflight_cnt, pending_mask); end
      issue_rd(6);
      issue_rd(6);
      wb_valid = 1; wb_rd = 6; kill_valid = 1; kill_rd = 6;
      tick();
      idle();
      checks++; if (inflight_cnt !== 4'd1 || pending_mask !== 32'h10 || err_underflow !== 1'b0) begin errors++; $display("FAIL sim_dec2: got inflight=%0d mask=%h err=%b want 1 00000010 0", inflight_cnt, pending_mask, err_underflow); end
   endtask

   task automatic test_long();
      do_reset();
      dec_valid = 1; dec_long = 1;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL long_first: got %b want 1", issue_ready); end
      tick();
      checks++; if (long_busy !== 1'b1) begin errors++; $display("FAIL long_busy_set: got %b want 1", long_busy); end
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL long_stall: got %b want 0", issue_ready); end
      tick();
      long_done = 1;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL long_done_ready: got %b want 1", issue_ready); end
      tick();
      idle();
      checks++; if (long_busy !== 1'b1) begin errors++; $display("FAIL long_reaccept: got %b want 1", long_busy); end
      long_done = 1;
      tick();
      idle();
      checks++; if (long_busy !== 1'b0) begin errors++; $display("FAIL long_clear: got %b want 0", long_busy); end
      long_done = 1;
      tick();
      idle();
      checks++; if (long_busy !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("FAIL long_idle_done: got busy=%b err=%b want 0 0", long_busy, err_underflow); end
   endtask

   task automatic test_reg0_underflow();
      do_reset();
      issue_rd(0);
      checks++; if (pending_mask !== 32'h0 || inflight_cnt !== 4'd0) begin errors++; $display("FAIL r0_issue: got mask=%h inflight=%0d want 0 0", pending_mask, inflight_cnt); end
      dec_valid = 1; dec_rs = 0; dec_rs_used = 1; dec_rd_wr = 1; dec_rd = 0;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b want 1", issue_ready); end
      idle();
      issue_rd(2);
      wb_valid = 1; wb_rd = 9;
      tick();
      idle();
      checks++; if (err_underflow !== 1'b1 || inflight_cnt !== 4'd1 || pending_mask !== 32'h4) begin errors++; $display("FAIL uf_set: got err=%b inflight=%0d mask=%h want 1 1 00000004", err_underflow, inflight_cnt, pending_mask); end
      tick();
      tick();
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
      do_reset();
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_reset: got %b want 0", err_underflow); end
   endtask

   initial begin
      idle();
      test_reset();
      test_reset_mid();
      test_raw();
      test_waw();
      test_simul();
      test_long();
      test_reg0_underflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
